// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks two WIDTH-bit operands CHUNK bits per
// clock from the MSB chunk down, unsigned or two's-complement, start/busy/done handshake.
module serial_magnitude_comparator #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CHUNK      = 2,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDX_W-1:0] idx;
  logic             diff_q;
  logic             gt_q;
  logic             lt_q;

  logic [WIDTH-1:0] a_cap;
  logic [WIDTH-1:0] b_cap;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic             cmp_gt;
  logic             cmp_lt;
  logic             new_gt;
  logic             new_lt;
  logic             new_diff;
  logic             finish;

  // Signed compare becomes unsigned once the sign bits are flipped (offset binary).
  assign a_cap = signed_mode ? (a ^ MSB_MASK) : a;
  assign b_cap = signed_mode ? (b ^ MSB_MASK) : b;

  assign chunk_a = CHUNK'(a_q >> (32'(idx) * CHUNK));
  assign chunk_b = CHUNK'(b_q >> (32'(idx) * CHUNK));
  assign cmp_gt  = (chunk_a > chunk_b);
  assign cmp_lt  = (chunk_a < chunk_b);

  // The first recorded difference wins; later chunks cannot overwrite it.
  assign new_gt   = diff_q ? gt_q : cmp_gt;
  assign new_lt   = diff_q ? lt_q : cmp_lt;
  assign new_diff = diff_q | cmp_gt | cmp_lt;
  assign finish   = (idx == '0) || ((EARLY_EXIT != 0) && (cmp_gt || cmp_lt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      diff_q <= 1'b0;
      gt_q   <= 1'b0;
      lt_q   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      a_gt_b <= 1'b0;
      a_lt_b <= 1'b0;
      a_eq_b <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a_cap;
            b_q    <= b_cap;
            idx    <= IDX_TOP;
            diff_q <= 1'b0;
            gt_q   <= 1'b0;
            lt_q   <= 1'b0;
            busy   <= 1'b1;
            state  <= CMP;
          end
        end
        CMP: begin
          if (finish) begin
            a_gt_b <= new_gt;
            a_lt_b <= new_lt;
            a_eq_b <= ~new_diff;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            idx    <= idx - IDX_W'(1);
            diff_q <= new_diff;
            gt_q   <= new_gt;
            lt_q   <= new_lt;
          end
        end
        DONE: begin
          // Leaving DONE doubles as the earliest accept point for back-to-back compares.
          if (start) begin
            a_q    <= a_cap;
            b_q    <= b_cap;
            idx    <= IDX_TOP;
            diff_q <= 1'b0;
            gt_q   <= 1'b0;
            lt_q   <= 1'b0;
            state  <= CMP;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
